// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: ALU, branch/jump resolution and the EX/MEM register.
// Define EX_MULDIV_EN to build in the iterative RV32M unit, which stalls the front end while it runs.
module ex_stage #(
  parameter int MULDIV_ITER = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ID_Valid,
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_Rs1_data,
  input  logic [31:0] ID_Rs2_data,
  input  logic [31:0] ID_Imm,
  input  logic [3:0]  ID_ALU_op,
  input  logic        ID_ALU_srcA,
  input  logic        ID_ALU_srcB,
  input  logic        ID_Branch,
  input  logic [2:0]  ID_Br_op,
  input  logic [1:0]  ID_Jump,
  input  logic        ID_MulDiv,
  input  logic [2:0]  ID_MulDiv_op,
  input  logic        ID_Mem_wr_en,
  input  logic        ID_Mem_rd_en,
  input  logic        ID_MemToReg,
  input  logic        ID_RegFile_wr_en,
  input  logic [2:0]  ID_Mem_op,
  input  logic [4:0]  ID_Rd_addr,
  input  logic        EX_Flush,
  output logic        EX_Stall,
  output logic [31:0] EX_ALU_result,
  output logic [31:0] EX_Rs2_data,
  output logic        EX_Mem_wr_en,
  output logic        EX_Mem_rd_en,
  output logic        EX_MemToReg,
  output logic        EX_RegFile_wr_en,
  output logic [2:0]  EX_Mem_op,
  output logic [4:0]  EX_Rd_addr,
  output logic        EX_Branch_taken,
  output logic [31:0] EX_Branch_target
);

  logic [31:0] op_a, op_b, alu;
  logic        br_cond, taken, bubble;
  logic [31:0] pc_plus4, target;
  logic        md_done;
  logic [31:0] md_result;

  always_comb begin
    op_a = ID_ALU_srcA ? ID_PC  : ID_Rs1_data;
    op_b = ID_ALU_srcB ? ID_Imm : ID_Rs2_data;
    case (ID_ALU_op)
      4'd0:    alu = op_a + op_b;
      4'd1:    alu = op_a - op_b;
      4'd2:    alu = op_a << op_b[4:0];
      4'd3:    alu = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd4:    alu = {31'd0, op_a < op_b};
      4'd5:    alu = op_a ^ op_b;
      4'd6:    alu = op_a >> op_b[4:0];
      4'd7:    alu = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'd8:    alu = op_a | op_b;
      4'd9:    alu = op_a & op_b;
      4'd10:   alu = op_b;
      default: alu = 32'd0;
    endcase
  end

  // Branches always compare the register operands, independent of the ALU source muxes.
  always_comb begin
    case (ID_Br_op)
      3'd0:    br_cond = ID_Rs1_data == ID_Rs2_data;
      3'd1:    br_cond = ID_Rs1_data != ID_Rs2_data;
      3'd4:    br_cond = $signed(ID_Rs1_data) <  $signed(ID_Rs2_data);
      3'd5:    br_cond = $signed(ID_Rs1_data) >= $signed(ID_Rs2_data);
      3'd6:    br_cond = ID_Rs1_data <  ID_Rs2_data;
      3'd7:    br_cond = ID_Rs1_data >= ID_Rs2_data;
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_plus4 = ID_PC + 32'd4;
  assign target   = (ID_Jump == 2'd2) ? ((ID_Rs1_data + ID_Imm) & ~32'd1) : (ID_PC + ID_Imm);
  assign taken    = (ID_Jump == 2'd1) || (ID_Jump == 2'd2) || (ID_Branch && br_cond);

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  md_state_t   state;
  logic [31:0] hi, lo, mop;
  logic [4:0]  cnt;
  logic [2:0]  md_op;
  logic        a_neg, b_neg, div0;
  logic [31:0] dividend;
  logic        start, is_mul, a_sgn, b_sgn, a_n, b_n;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [63:0] prod, prod_s;

  assign start    = (state == IDLE) && ID_Valid && ID_MulDiv && !EX_Flush;
  assign EX_Stall = start || (state == BUSY);
  assign md_done  = (state == DONE);

  // Signedness of each operand: MULH s*s, MULHSU s*u, MUL/MULHU u*u (low word is sign-agnostic).
  always_comb begin
    is_mul = !ID_MulDiv_op[2];
    a_sgn  = is_mul ? (ID_MulDiv_op == 3'd1 || ID_MulDiv_op == 3'd2) : !ID_MulDiv_op[0];
    b_sgn  = is_mul ? (ID_MulDiv_op == 3'd1) : !ID_MulDiv_op[0];
    a_n    = a_sgn && ID_Rs1_data[31];
    b_n    = b_sgn && ID_Rs2_data[31];
    a_mag  = a_n ? -ID_Rs1_data : ID_Rs1_data;
    b_mag  = b_n ? -ID_Rs2_data : ID_Rs2_data;
  end

  // hi:lo is the shift-right product register for mul and remainder:quotient for div.
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mop} : 33'd0);
  assign div_shift = {hi, lo[31]};
  assign div_trial = div_shift - {1'b0, mop};

  always_comb begin
    prod   = {hi, lo};
    prod_s = (a_neg ^ b_neg) ? -prod : prod;
    case (md_op)
      3'd0:       md_result = prod_s[31:0];
      3'd1, 3'd2,
      3'd3:       md_result = prod_s[63:32];
      3'd4, 3'd5: md_result = div0 ? 32'hFFFF_FFFF : ((a_neg ^ b_neg) ? -lo : lo);
      default:    md_result = div0 ? dividend : (a_neg ? -hi : hi);
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      mop      <= '0;
      cnt      <= '0;
      md_op    <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div0     <= 1'b0;
      dividend <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= BUSY;
          cnt      <= '0;
          md_op    <= ID_MulDiv_op;
          a_neg    <= a_n;
          b_neg    <= b_n;
          div0     <= (ID_Rs2_data == 32'd0);
          dividend <= ID_Rs1_data;
          hi       <= '0;
          lo       <= is_mul ? b_mag : a_mag;
          mop      <= is_mul ? a_mag : b_mag;
        end
        BUSY: if (EX_Flush) begin
          state <= IDLE;
        end else begin
          if (!md_op[2]) begin
            hi <= mul_sum[32:1];
            lo <= {mul_sum[0], lo[31:1]};
          end else if (!div_trial[32]) begin
            hi <= div_trial[31:0];
            lo <= {lo[30:0], 1'b1};
          end else begin
            hi <= div_shift[31:0];
            lo <= {lo[30:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(MULDIV_ITER - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{ID_MulDiv, ID_MulDiv_op, 32'(MULDIV_ITER)};
  assign EX_Stall  = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = 32'd0;
`endif

  assign bubble = EX_Flush || !ID_Valid || EX_Stall;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset || bubble) begin
      EX_ALU_result    <= '0;
      EX_Rs2_data      <= '0;
      EX_Mem_wr_en     <= 1'b0;
      EX_Mem_rd_en     <= 1'b0;
      EX_MemToReg      <= 1'b0;
      EX_RegFile_wr_en <= 1'b0;
      EX_Mem_op        <= '0;
      EX_Rd_addr       <= '0;
      EX_Branch_taken  <= 1'b0;
      EX_Branch_target <= '0;
    end else begin
      EX_ALU_result    <= md_done ? md_result : ((ID_Jump == 2'd1 || ID_Jump == 2'd2) ? pc_plus4 : alu);
      EX_Rs2_data      <= ID_Rs2_data;
      EX_Mem_wr_en     <= ID_Mem_wr_en;
      EX_Mem_rd_en     <= ID_Mem_rd_en;
      EX_MemToReg      <= ID_MemToReg;
      EX_RegFile_wr_en <= ID_RegFile_wr_en;
      EX_Mem_op        <= ID_Mem_op;
      EX_Rd_addr       <= ID_Rd_addr;
      EX_Branch_taken  <= taken && !md_done;
      EX_Branch_target <= target;
    end
  end

endmodule
